dram_ref_sched: RTL and testbench
=================================

// Module: dram_ref_sched
// PURPOSE
//  Refresh scheduler and DRAM access arbiter for the on-board DRAM array on FCLK.
//  Counts refresh intervals and queues owed refreshes.
//  Arbitrates the DRAM between FSB RAM cycles and CAS-before-RAS refresh sequences, and drives the refresh strobes.
//  Exports RefReq/RefUrg for QoS/FSB logic; the RAM block gates its own RAS/CAS with RAMGnt.
// PARAMETERS
//  REF_PERIOD  375  FCLK cycles per owed refresh (15 us at 25 MHz)
//  URG_THRESH  2    pending count at which refresh pre-empts FSB RAM cycles
//  MAX_PEND    4    pending-counter saturation value (3-bit counter)
//  TRAS        3    cycles RefRAS is held asserted
//  TRP         2    precharge cycles after RefRAS/RefCAS release
// PORTS
//  CLK      in   1  FCLK; all logic rising-edge
//  RES      in   1  synchronous active-high reset
//  RAMReq   in   1  FSB RAM cycle pending (level, held until granted and ended)
//  RAMEnd   in   1  one-cycle pulse: granted RAM cycle complete
//  RAMGnt   out  1  DRAM owned by FSB cycle
//  RefCAS   out  1  refresh CAS strobe, active high
//  RefRAS   out  1  refresh RAS strobe, active high
//  RefBusy  out  1  refresh sequence in progress
//  RefReq   out  1  RefPend != 0
//  RefUrg   out  1  RefPend >= URG_THRESH
//  RefPend  out  3  owed refresh count
//  RefOvf   out  1  sticky: tick arrived while RefPend == MAX_PEND
// BEHAVIOUR
//  Reset: all outputs 0, tick counter 0, state IDLE. Reset mid-refresh drops RefRAS/RefCAS at that edge; the owed count is lost.
//  Tick: counter 0..REF_PERIOD-1; at wrap, RefPend+1, saturating at MAX_PEND.
//  Tick at saturation sets RefOvf; RefOvf is cleared only by RES.
//  RefPend decrements by 1 on the cycle leaving RPRE.
//  Simultaneous tick and decrement: RefPend unchanged; RefOvf is not set.
//  All outputs registered. RefReq/RefUrg follow registered RefPend (same cycle).
//  FSM states: IDLE, RAM, RCAS, RRAS, RPRE.
//   IDLE: priority is (1) RefUrg -> RCAS, (2) RAMReq -> RAM, (3) RefReq -> RCAS, (4) stay.
//   RAM: RAMGnt=1 (asserted the cycle after RAMReq was sampled in IDLE). On RAMEnd -> IDLE; RAMGnt=0 next cycle.
//    Refresh never interrupts RAM; urgency only wins at IDLE.
//   RCAS: 1 cycle; RefCAS=1, RefRAS=0 -> RRAS.
//   RRAS: TRAS cycles; RefCAS=1, RefRAS=1 -> RPRE.
//   RPRE: TRP cycles; both strobes 0 -> IDLE, with RefPend decremented.
//  RefBusy=1 in RCAS/RRAS/RPRE. RAMGnt and RefBusy are never both 1.
//  IDLE always lasts >= 1 cycle between grants; RAMReq still high on the cycle after RAMEnd is a new request.
//  RAMEnd outside RAM is ignored. RAMReq dropped before grant: no grant.
//  Refresh sequence length = 1 + TRAS + TRP cycles; RCAS-entry-to-RefPend-decrement = 1+TRAS+TRP.
// TESTING (bench params REF_PERIOD=8 URG_THRESH=2 MAX_PEND=4 TRAS=3 TRP=2)
//  Idle, no RAMReq, release RES at t0 -> RefPend=1 at t0+8; RefCAS 1 cycle, RefRAS 3 cycles, 2 precharge; RefPend back to 0.
//  RAMReq held high continuously with RAMEnd 2 cycles after each grant -> refresh runs only once RefPend=2 (RefUrg) at an IDLE boundary; RAMGnt/RefBusy never overlap.
//  RAMReq and RefPend=1 in IDLE together -> RAMGnt wins; refresh starts the IDLE after RAMEnd.
//  RAMGnt held (no RAMEnd) for 40 cycles -> RefPend saturates at 4; RefOvf=1 on the 5th tick; RefOvf stays 1 after drain.
//  Tick coinciding with RPRE exit -> RefPend unchanged that cycle.
//  RES asserted during RRAS -> next edge: RefRAS=RefCAS=RefBusy=RAMGnt=0, RefPend=0, RefOvf=0.

Source files
------------

// File: rtl/dram_ref_sched.sv
// rtl/dram_ref_sched.sv - DRAM refresh scheduler and FSB/refresh access arbiter
// Owed refreshes accumulate on an interval timer and are drained by CAS-before-RAS sequences.
module dram_ref_sched #(
    parameter int REF_PERIOD = 375,
    parameter int URG_THRESH = 2,
    parameter int MAX_PEND   = 4,
    parameter int TRAS       = 3,
    parameter int TRP        = 2
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       RAMReq,
    input  logic       RAMEnd,
    output logic       RAMGnt,
    output logic       RefCAS,
    output logic       RefRAS,
    output logic       RefBusy,
    output logic       RefReq,
    output logic       RefUrg,
    output logic [2:0] RefPend,
    output logic       RefOvf
);

    localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int PW = $clog2(TRAS + TRP + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(REF_PERIOD - 1);
    localparam logic [PW-1:0] RAS_LAST  = PW'(TRAS - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TRP - 1);
    localparam logic [2:0]    PEND_MAX  = 3'(MAX_PEND);
    localparam logic [2:0]    PEND_URG  = 3'(URG_THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM,
        S_RCAS,
        S_RRAS,
        S_RPRE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          ram_gnt_q, ram_gnt_d;
    logic          ref_cas_q, ref_cas_d;
    logic          ref_ras_q, ref_ras_d;
    logic          ref_busy_q, ref_busy_d;
    logic          ref_req_q, ref_req_d;
    logic          ref_urg_q, ref_urg_d;
    logic          tick;
    logic          ref_done;

    assign tick     = (tick_cnt_q == TICK_LAST);
    assign ref_done = (state_q == S_RPRE) && (phase_q == PRE_LAST);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            phase_q    <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            ram_gnt_q  <= 1'b0;
            ref_cas_q  <= 1'b0;
            ref_ras_q  <= 1'b0;
            ref_busy_q <= 1'b0;
            ref_req_q  <= 1'b0;
            ref_urg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            ram_gnt_q  <= ram_gnt_d;
            ref_cas_q  <= ref_cas_d;
            ref_ras_q  <= ref_ras_d;
            ref_busy_q <= ref_busy_d;
            ref_req_q  <= ref_req_d;
            ref_urg_q  <= ref_urg_d;
        end
    end

    // A tick and a completed refresh in the same cycle cancel out, so no overflow either.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        pend_d     = pend_q;
        ovf_d      = ovf_q;
        if (tick && !ref_done) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 3'd1;
            end
        end else if (ref_done && !tick) begin
            pend_d = pend_q - 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = '0;
        case (state_q)
            S_IDLE: begin
                if (ref_urg_q) begin
                    state_d = S_RCAS;
                end else if (RAMReq) begin
                    state_d = S_RAM;
                end else if (ref_req_q) begin
                    state_d = S_RCAS;
                end
            end
            S_RAM: begin
                if (RAMEnd) begin
                    state_d = S_IDLE;
                end
            end
            S_RCAS: state_d = S_RRAS;
            S_RRAS: begin
                if (phase_q == RAS_LAST) begin
                    state_d = S_RPRE;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_RPRE: begin
                if (phase_q == PRE_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they appear registered with the state.
    always_comb begin
        ram_gnt_d  = (state_d == S_RAM);
        ref_cas_d  = (state_d == S_RCAS) || (state_d == S_RRAS);
        ref_ras_d  = (state_d == S_RRAS);
        ref_busy_d = (state_d == S_RCAS) || (state_d == S_RRAS) || (state_d == S_RPRE);
        ref_req_d  = (pend_d != 3'd0);
        ref_urg_d  = (pend_d >= PEND_URG);
    end

    assign RAMGnt  = ram_gnt_q;
    assign RefCAS  = ref_cas_q;
    assign RefRAS  = ref_ras_q;
    assign RefBusy = ref_busy_q;
    assign RefReq  = ref_req_q;
    assign RefUrg  = ref_urg_q;
    assign RefPend = pend_q;
    assign RefOvf  = ovf_q;

endmodule

// File: tb/tb_dram_ref_sched.sv
// tb/tb_dram_ref_sched.sv - testbench for dram_ref_sched
module tb_dram_ref_sched;

    localparam int REF_PERIOD = 8;
    localparam int URG_THRESH = 2;
    localparam int MAX_PEND   = 4;
    localparam int TRAS       = 3;
    localparam int TRP        = 2;
    localparam int SEQ_LEN    = 1 + TRAS + TRP;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       RAMReq = 1'b0;
    logic       RAMEnd = 1'b0;
    logic       RAMGnt, RefCAS, RefRAS, RefBusy, RefReq, RefUrg, RefOvf;
    logic [2:0] RefPend;

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    dram_ref_sched #(
        .REF_PERIOD(REF_PERIOD),
        .URG_THRESH(URG_THRESH),
        .MAX_PEND  (MAX_PEND),
        .TRAS      (TRAS),
        .TRP       (TRP)
    ) dut (
        .CLK    (CLK),
        .RES    (RES),
        .RAMReq (RAMReq),
        .RAMEnd (RAMEnd),
        .RAMGnt (RAMGnt),
        .RefCAS (RefCAS),
        .RefRAS (RefRAS),
        .RefBusy(RefBusy),
        .RefReq (RefReq),
        .RefUrg (RefUrg),
        .RefPend(RefPend),
        .RefOvf (RefOvf)
    );

    always #5 CLK = ~CLK;

    // Model: owner is either the FSB (m_gnt), a refresh at position m_pos, or nobody.
    int m_cnt  = 0;
    int m_pend = 0;
    int m_pos  = -1;
    bit m_ovf  = 1'b0;
    bit m_gnt  = 1'b0;
    bit m_tick, m_done;

    always @(posedge CLK) begin
        if (RES) begin
            m_cnt  = 0;
            m_pend = 0;
            m_pos  = -1;
            m_ovf  = 1'b0;
            m_gnt  = 1'b0;
        end else begin
            m_tick = (m_cnt == REF_PERIOD - 1);
            m_cnt  = (m_cnt + 1) % REF_PERIOD;
            m_done = (m_pos == SEQ_LEN - 1);
            if (m_gnt) begin
                if (RAMEnd) m_gnt = 1'b0;
            end else if (m_pos >= 0) begin
                m_pos = m_done ? -1 : m_pos + 1;
            end else if (m_pend >= URG_THRESH) begin
                m_pos = 0;
            end else if (RAMReq) begin
                m_gnt = 1'b1;
            end else if (m_pend > 0) begin
                m_pos = 0;
            end
            if (m_tick && !m_done) begin
                if (m_pend == MAX_PEND) m_ovf = 1'b1;
                else m_pend = m_pend + 1;
            end else if (m_done && !m_tick) begin
                m_pend = m_pend - 1;
            end
        end
    end

    function automatic logic [9:0] exp_out();
        logic cas, ras, busy;
        busy = (m_pos >= 0);
        cas  = (m_pos >= 0) && (m_pos <= TRAS);
        ras  = (m_pos >= 1) && (m_pos <= TRAS);
        return {m_gnt, cas, ras, busy, (m_pend != 0), (m_pend >= URG_THRESH),
                3'(m_pend), m_ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en)
            check("cycle_outputs",
                  {22'd0, RAMGnt, RefCAS, RefRAS, RefBusy, RefReq, RefUrg, RefPend, RefOvf},
                  {22'd0, exp_out()});
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RES    = 1'b1;
        RAMReq = 1'b0;
        RAMEnd = 1'b0;
        step(2);
        RES = 1'b0;
    endtask

    initial begin
        int g;
        int n_ref;
        bit ok;

        do_reset();
        chk_en = 1'b1;

        // Idle refresh: tick after 8 edges, then CAS 1, RAS 3, precharge 2
        step(7);
        check("a_pend_e7", RefPend, 0);
        step(1);
        check("a_pend_e8", RefPend, 1);
        check("a_req_e8", RefReq, 1);
        check("a_busy_e8", RefBusy, 0);
        step(1);
        check("a_cas_e9", {RefCAS, RefRAS, RefBusy}, 3'b101);
        step(1);
        check("a_ras_e10", {RefCAS, RefRAS}, 2'b11);
        step(3);
        check("a_pre_e13", {RefCAS, RefRAS, RefBusy}, 3'b001);
        step(2);
        check("a_done_e15", {RefBusy, RefPend}, 4'b0000);

        // Tick lands on the precharge exit: pending count holds
        do_reset();
        step(7);
        RAMReq = 1'b1;
        step(1);
        check("b_gnt_e8", {RAMGnt, RefPend}, 4'b1001);
        RAMReq = 1'b0;
        RAMEnd = 1'b1;
        step(1);
        check("b_gnt_e9", RAMGnt, 0);
        RAMEnd = 1'b0;
        step(1);
        check("b_cas_e10", RefCAS, 1);
        step(5);
        check("b_pre_e15", {RefBusy, RefPend}, 4'b1001);
        step(1);
        check("b_exit_e16", {RefBusy, RefPend, RefUrg}, 5'b00010);

        // FSB request beats a non-urgent refresh
        do_reset();
        step(8);
        RAMReq = 1'b1;
        step(1);
        check("c_gnt_e9", {RAMGnt, RefBusy}, 2'b10);
        step(1);
        RAMEnd = 1'b1;
        RAMReq = 1'b0;
        step(1);
        check("c_end_e11", {RAMGnt, RefBusy}, 2'b00);
        RAMEnd = 1'b0;
        step(1);
        check("c_cas_e12", {RefCAS, RefBusy}, 2'b11);

        // Back-to-back FSB cycles: refresh only when urgent
        do_reset();
        RAMReq = 1'b1;
        g      = 0;
        n_ref  = 0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            check("d_overlap", RAMGnt & RefBusy, 0);
            if (RefCAS && !RefRAS) begin
                n_ref++;
                check("d_urg_at_rcas", RefPend >= 3'd2, 1);
            end
            if (RAMGnt) g++;
            else g = 0;
            RAMEnd = (g == 2);
        end
        RAMReq = 1'b0;
        RAMEnd = 1'b0;
        check("d_refresh_seen", n_ref > 0, 1);

        // Long FSB hold: saturation and sticky overflow
        do_reset();
        RAMReq = 1'b1;
        step(39);
        check("e_sat_e39", {RAMGnt, RefPend, RefOvf}, 5'b11000);
        step(1);
        check("e_ovf_e40", {RefPend, RefOvf}, 4'b1001);
        RAMReq = 1'b0;
        RAMEnd = 1'b1;
        step(1);
        RAMEnd = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            step(1);
            ok = (RefPend == 3'd0);
        end
        check("e_drained", ok, 1);
        check("e_ovf_sticky", RefOvf, 1);

        // Reset during RAS drops everything at the next edge
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step(1);
            ok = RefRAS;
        end
        check("f_in_rras", ok, 1);
        RES = 1'b1;
        step(1);
        check("f_reset_outs",
              {RAMGnt, RefCAS, RefRAS, RefBusy, RefReq, RefUrg, RefPend, RefOvf}, 0);
        RES = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
